// File: rtl/ram_lsu_pkg.sv
// lsu_pkg: shared constants for the RAM load/store unit.
//   LSU_DATA_W  : data path width (32 only)
//   F3_*        : RV32I funct3 width/sign codes
//   state_t     : LSU sequencing states
//   f3_legal    : funct3 legality for loads/stores
//   f3_misaligned : natural-alignment violation for a funct3/address pair
package lsu_pkg;

   localparam int unsigned LSU_DATA_W = 32;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_H, F3_HU: return lo[0];
         F3_W:        return |lo;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// ram_lsu_if: core request/response and RAM port bundle of the LSU.
//   REQ_*  : core access request (valid/ready handshake)
//   RSP_*  : response to the core (valid/ready handshake)
//   MEM_*  : single-port RAM, combinational read, write on rising edge
// Modports: slave = LSU side, master = core + RAM side.
interface ram_lsu_if
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);
   logic                  REQ_VALID;
   logic                  REQ_READY;
   logic                  REQ_WE;
   logic [2:0]            REQ_FUNCT3;
   logic [ADDR_W-1:0]     REQ_ADDR;
   logic [LSU_DATA_W-1:0] REQ_WDATA;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [LSU_DATA_W-1:0] RSP_RDATA;
   logic                  RSP_ERR;
   logic [ADDR_W-1:0]     MEM_A;
   logic [LSU_DATA_W-1:0] MEM_D;
   logic                  MEM_WE;
   logic [LSU_DATA_W-1:0] MEM_Q;

   modport slave (
      input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_Q,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_A, MEM_D, MEM_WE
   );

   modport master (
      output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_Q,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_A, MEM_D, MEM_WE
   );
endinterface

// File: rtl/ram_lsu_lane.sv
// lsu_lane: combinational byte-lane logic of the LSU.
//   funct3  : access width/sign code
//   lane    : address bits [1:0]
//   rd_word : RAM word being loaded from
//   st_base : RAM word captured before a sub-word store
//   st_data : right-aligned store data
//   ld_data : extracted and sign/zero extended load result
//   st_word : st_base with the addressed lanes replaced by st_data
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [1:0]            lane,
   input  logic [LSU_DATA_W-1:0] rd_word,
   input  logic [LSU_DATA_W-1:0] st_base,
   input  logic [LSU_DATA_W-1:0] st_data,
   output logic [LSU_DATA_W-1:0] ld_data,
   output logic [LSU_DATA_W-1:0] st_word
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rd_word[{lane, 3'b000} +: 8];
      half_v = lane[1] ? rd_word[31:16] : rd_word[15:0];

      ld_data = '0;
      case (funct3)
         F3_B:    ld_data = {{24{byte_v[7]}}, byte_v};
         F3_H:    ld_data = {{16{half_v[15]}}, half_v};
         F3_W:    ld_data = rd_word;
         F3_BU:   ld_data = {24'd0, byte_v};
         F3_HU:   ld_data = {16'd0, half_v};
         default: ld_data = '0;
      endcase

      st_word = st_base;
      case (funct3)
         F3_B: st_word[{lane, 3'b000} +: 8] = st_data[7:0];
         F3_H: begin
            if (lane[1]) st_word[31:16] = st_data[15:0];
            else         st_word[15:0]  = st_data[15:0];
         end
         default: st_word = st_data;
      endcase
   end
endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: single-outstanding load/store unit in front of a word RAM.
//   CLK, RSTN : clock, asynchronous active-low reset
//   bus       : ram_lsu_if.slave (core request/response + RAM port)
// Sub-word stores are read-modify-write (READ then WRITE).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses return
// RSP_ERR instead of being silently aligned.
module ram_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
)(
   input  logic    CLK,
   input  logic    RSTN,
   ram_lsu_if.slave bus
);
   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          f3_q, f3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                req_bad;
   logic [DATA_W-1:0]   ld_data, st_word;

   lsu_lane u_lane (
      .funct3  (f3_q),
      .lane    (addr_q[1:0]),
      .rd_word (bus.MEM_Q),
      .st_base (word_q),
      .st_data (wdata_q),
      .ld_data (ld_data),
      .st_word (st_word)
   );

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      req_bad = !f3_legal(bus.REQ_WE, bus.REQ_FUNCT3) ||
                f3_misaligned(bus.REQ_FUNCT3, bus.REQ_ADDR[1:0]);
`else
      req_bad = !f3_legal(bus.REQ_WE, bus.REQ_FUNCT3);
`endif
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      bus.REQ_READY = 1'b0;
      bus.RSP_VALID = 1'b0;
      bus.RSP_RDATA = rdata_q;
      bus.RSP_ERR   = err_q;
      bus.MEM_A     = '0;
      bus.MEM_D     = '0;
      bus.MEM_WE    = 1'b0;

      case (state_q)
         IDLE: begin
            bus.REQ_READY = 1'b1;
            if (bus.REQ_VALID) begin
               we_d    = bus.REQ_WE;
               f3_d    = bus.REQ_FUNCT3;
               wdata_d = bus.REQ_WDATA;
               rdata_d = '0;
               // Natural alignment: halves drop bit 0, words drop bits 1:0.
               addr_d  = bus.REQ_ADDR;
               case (bus.REQ_FUNCT3)
                  F3_H, F3_HU: addr_d[0]   = 1'b0;
                  F3_W:        addr_d[1:0] = 2'b00;
                  default:     ;
               endcase
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (bus.REQ_WE && (bus.REQ_FUNCT3 == F3_W)) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            bus.MEM_A = {addr_q[ADDR_W-1:2], 2'b00};
            if (we_q) begin
               word_d  = bus.MEM_Q;
               state_d = WRITE;
            end else begin
               rdata_d = ld_data;
               state_d = RESP;
            end
         end
         WRITE: begin
            bus.MEM_A  = {addr_q[ADDR_W-1:2], 2'b00};
            bus.MEM_WE = 1'b1;
            bus.MEM_D  = (f3_q == F3_W) ? wdata_q : st_word;
            state_d    = RESP;
         end
         RESP: begin
            bus.RSP_VALID = 1'b1;
            if (bus.RSP_READY) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: self-checking bench for ram_lsu with a behavioural RAM and
// a word-array reference model of loads, stores and error decisions.
module tb_ram_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ram_lsu_if #(.ADDR_W(32)) bus ();

   ram_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus)
   );

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];

   assign bus.MEM_Q = ram[bus.MEM_A[9:2]];
   always @(posedge clk) if (bus.MEM_WE) ram[bus.MEM_A[9:2]] <= bus.MEM_D;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int a_cnt    = 0;

   always @(negedge clk) begin
      if (bus.MEM_WE) we_cnt++;
      if (bus.MEM_A != 0) a_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> (8 * addr[1:0]));
      h = 16'(word >> (16 * addr[1]));
      case (f3)
         3'd0:    return 32'($signed(b));
         3'd1:    return 32'($signed(h));
         3'd2:    return word;
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] exp_store(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] mask, val;
      case (f3)
         3'd0: begin
            mask = 32'hFF << (8 * addr[1:0]);
            val  = (wd & 32'hFF) << (8 * addr[1:0]);
         end
         3'd1: begin
            mask = 32'hFFFF << (16 * addr[1]);
            val  = (wd & 32'hFFFF) << (16 * addr[1]);
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            val  = wd;
         end
      endcase
      return (old & ~mask) | val;
   endfunction

   function automatic logic exp_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic legal;
      int   size;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      return !legal || ((addr % size) != 0);
`else
      if (size == 0) return 1'b1;
      return !legal;
`endif
   endfunction

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat);
      int guard = 0;
      @(negedge clk);
      while (!bus.REQ_READY && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready_wait", 32'(bus.REQ_READY), 32'd1);
      bus.REQ_VALID  = 1'b1;
      bus.REQ_WE     = we;
      bus.REQ_FUNCT3 = f3;
      bus.REQ_ADDR   = addr;
      bus.REQ_WDATA  = wd;
      @(posedge clk);
      #1 bus.REQ_VALID = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.RSP_VALID && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_timeout", 32'(bus.RSP_VALID), 32'd1);
      rd  = bus.RSP_RDATA;
      err = bus.RSP_ERR;
      @(posedge clk);
      #1;
   endtask

   task automatic run_check(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input string tag);
      logic [31:0] rd;
      logic        err, e_err;
      int          lat, e_lat, w0, a0;
      logic [7:0]  widx;
      widx  = addr[9:2];
      e_err = exp_error(we, f3, addr);
      e_lat = e_err ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
      w0 = we_cnt;
      a0 = a_cnt;
      do_req(we, f3, addr, wd, rd, err, lat);
      check({tag, "_err"}, 32'(err), 32'(e_err));
      check({tag, "_rdata"}, rd, (we || e_err) ? 32'd0 : exp_load(f3, addr, ref_mem[widx]));
      check({tag, "_lat"}, 32'(lat), 32'(e_lat));
      check({tag, "_we_cycles"}, 32'(we_cnt - w0), (we && !e_err) ? 32'd1 : 32'd0);
      check({tag, "_mem_cycles"}, 32'(a_cnt - a0), 32'(e_lat - 1));
      if (we && !e_err) ref_mem[widx] = exp_store(f3, addr, ref_mem[widx], wd);
      check({tag, "_ram"}, ram[widx], ref_mem[widx]);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          lat, w0, a0, guard;

      for (int i = 0; i < 256; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      bus.REQ_VALID  = 1'b0;
      bus.REQ_WE     = 1'b0;
      bus.REQ_FUNCT3 = '0;
      bus.REQ_ADDR   = '0;
      bus.REQ_WDATA  = '0;
      bus.RSP_READY  = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("rst_rsp_rdata", bus.RSP_RDATA, 32'd0);
      check("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
      check("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
      check("rst_mem_a", bus.MEM_A, 32'd0);
      check("rst_mem_d", bus.MEM_D, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.REQ_READY), 32'd1);

      // LB / LBU on 0x8899AABB
      ram[8'h10] = 32'h8899AABB; ref_mem[8'h10] = 32'h8899AABB;
      do_req(1'b0, 3'd0, 32'h41, 32'd0, rd, err, lat);
      check("lb_rdata", rd, 32'hFFFFFFAA);
      check("lb_lat", 32'(lat), 32'd2);
      check("lb_err", 32'(err), 32'd0);
      do_req(1'b0, 3'd4, 32'h41, 32'd0, rd, err, lat);
      check("lbu_rdata", rd, 32'h000000AA);

      // SB into 0x11223344
      ram[8'h04] = 32'h11223344; ref_mem[8'h04] = 32'h11223344;
      w0 = we_cnt;
      do_req(1'b1, 3'd0, 32'h12, 32'h000000EE, rd, err, lat);
      check("sb_ram", ram[8'h04], 32'h11EE3344);
      check("sb_we_cycles", 32'(we_cnt - w0), 32'd1);
      check("sb_rdata", rd, 32'd0);
      ref_mem[8'h04] = 32'h11EE3344;

      // SW then LW with response back-pressure
      run_check(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, "sw_20");
      @(negedge clk);
      bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_FUNCT3 = 3'd2; bus.REQ_ADDR = 32'h20;
      bus.RSP_READY = 1'b0;
      @(posedge clk);
      #1 bus.REQ_VALID = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!bus.RSP_VALID && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.REQ_VALID = 1'b1;   // must not be accepted while the response is pending
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
         check("hold_rsp_rdata", bus.RSP_RDATA, 32'hDEADBEEF);
         check("hold_rsp_err", 32'(bus.RSP_ERR), 32'd0);
         check("hold_req_ready", 32'(bus.REQ_READY), 32'd0);
         @(negedge clk);
      end
      bus.REQ_VALID = 1'b0;
      bus.RSP_READY = 1'b1;
      @(posedge clk);
      #1;
      check("hold_release_valid", 32'(bus.RSP_VALID), 32'd0);
      check("hold_release_ready", 32'(bus.REQ_READY), 32'd1);

      // LH at odd address
      run_check(1'b0, 3'd1, 32'h43, 32'd0, "lh_43");
      do_req(1'b0, 3'd1, 32'h43, 32'd0, rd, err, lat);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lh_43_trap_err", 32'(err), 32'd1);
      check("lh_43_trap_rdata", rd, 32'd0);
`else
      check("lh_43_align_err", 32'(err), 32'd0);
      check("lh_43_align_rdata", rd, 32'hFFFF8899);
`endif

      // illegal funct3
      run_check(1'b1, 3'd4, 32'h44, 32'h12345678, "sbu_illegal");
      run_check(1'b0, 3'd3, 32'h44, 32'd0, "ld3_illegal");
      run_check(1'b0, 3'd7, 32'h48, 32'd0, "ld7_illegal");

      // reset during the READ of a SH read-modify-write
      ram[8'h14] = 32'hCAFEF00D; ref_mem[8'h14] = 32'hCAFEF00D;
      w0 = we_cnt;
      a0 = a_cnt;
      @(negedge clk);
      bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_FUNCT3 = 3'd1;
      bus.REQ_ADDR = 32'h50; bus.REQ_WDATA = 32'h00001234;
      @(posedge clk);
      #1 bus.REQ_VALID = 1'b0;
      check("rmw_in_read", bus.MEM_A, 32'h50);
      rstn = 1'b0;
      #1;
      check("rr_mem_a", bus.MEM_A, 32'd0);
      check("rr_mem_d", bus.MEM_D, 32'd0);
      check("rr_mem_we", 32'(bus.MEM_WE), 32'd0);
      check("rr_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("rr_rsp_rdata", bus.RSP_RDATA, 32'd0);
      check("rr_rsp_err", 32'(bus.RSP_ERR), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("rr_req_ready", 32'(bus.REQ_READY), 32'd1);
      check("rr_ram_kept", ram[8'h14], 32'hCAFEF00D);
      check("rr_no_write", 32'(we_cnt - w0), 32'd0);
      do_req(1'b0, 3'd2, 32'h50, 32'd0, rd, err, lat);
      check("rr_lw_old", rd, 32'hCAFEF00D);

      // randomized traffic against the reference model
      for (int i = 0; i < 60; i++) begin
         run_check(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(4, 1023)), $urandom, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
